// File: rtl/x_pulse_stretch.sv
`default_nettype none
// ============================================================================
// Module   : x_pulse_stretch
// Purpose  : Stretches single-clock trigger pulses into a level output that
//            stays high for a programmable number of clocks. An optional
//            holdoff (dead time) follows each output. Triggers that cannot be
//            honoured are dropped and counted in a saturating counter.
// Ports    : clock    - system clock, rising edge
//            reset_n  - asynchronous active-low reset
//            p        - trigger, sampled every clock
//            width    - stretch length in clocks (0 behaves as 1)
//            holdoff  - dead time in clocks after q falls (0 = none)
//            retrig   - 1: trigger during stretch restarts it; 0: dropped
//            clr_lost - synchronous clear of nlost
//            q        - stretched level output (registered)
//            busy     - high while stretching or in holdoff (registered)
//            nlost    - saturating count of dropped triggers
// Revision : 1.0 - initial release
// ============================================================================
module x_pulse_stretch #(
  parameter int MXCNT  = 8,
  parameter int MXLOST = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              p,
  input  logic [MXCNT-1:0]  width,
  input  logic [MXCNT-1:0]  holdoff,
  input  logic              retrig,
  input  logic              clr_lost,
  output logic              q,
  output logic              busy,
  output logic [MXLOST-1:0] nlost
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  localparam logic [MXCNT-1:0]  C_ONE      = MXCNT'(1);
  localparam logic [MXLOST-1:0] C_LOST_MAX = '1;
  localparam logic [MXLOST-1:0] C_LOST_ONE = MXLOST'(1);

  state_t            state;
  state_t            state_nxt;
  logic [MXCNT-1:0]  cnt;
  logic [MXCNT-1:0]  cnt_nxt;
  logic [MXCNT-1:0]  hold_len;
  logic [MXCNT-1:0]  hold_len_nxt;
  logic [MXCNT-1:0]  width_eff;
  logic [MXLOST-1:0] nlost_nxt;
  logic              drop;

  // A zero width still produces a one-clock pulse.
  assign width_eff = (width == '0) ? C_ONE : width;

  // Next-state, counter and drop decode. The counter holds the number of
  // cycles remaining in the current state, including the present one, so a
  // value of 1 marks the last cycle.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    hold_len_nxt = hold_len;
    drop         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (p) begin
          state_nxt    = ST_STRETCH;
          cnt_nxt      = width_eff;
          hold_len_nxt = holdoff;
        end
      end
      ST_STRETCH: begin
        if (p && retrig) begin
          // Reload covers the last cycle too, so q never shows a low gap.
          cnt_nxt      = width_eff;
          hold_len_nxt = holdoff;
        end else begin
          drop = p;
          if (cnt <= C_ONE) begin
            if (hold_len != '0) begin
              state_nxt = ST_HOLD;
              cnt_nxt   = hold_len;
            end else begin
              state_nxt = ST_IDLE;
              cnt_nxt   = '0;
            end
          end else begin
            cnt_nxt = cnt - C_ONE;
          end
        end
      end
      ST_HOLD: begin
        drop = p;
        if (cnt <= C_ONE) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - C_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Clear wins over the old count, but a drop in the same cycle still counts.
  always_comb begin
    nlost_nxt = nlost;
    if (clr_lost) begin
      nlost_nxt = drop ? C_LOST_ONE : '0;
    end else if (drop && (nlost != C_LOST_MAX)) begin
      nlost_nxt = nlost + C_LOST_ONE;
    end
  end

  // q and busy are registered from the next state so they line up exactly
  // with the state register, giving one clock from trigger to q.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      hold_len <= '0;
      q        <= 1'b0;
      busy     <= 1'b0;
      nlost    <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      hold_len <= hold_len_nxt;
      q        <= (state_nxt == ST_STRETCH);
      busy     <= (state_nxt != ST_IDLE);
      nlost    <= nlost_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_x_pulse_stretch.sv
`default_nettype none
// ============================================================================
// Module   : tb_x_pulse_stretch
// Purpose  : Self-checking bench for x_pulse_stretch. Each scenario pushes
//            the expected {q, busy, nlost} for a cycle when it drives that
//            cycle's stimulus, then pops and compares after the clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_x_pulse_stretch;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       p = 1'b0;
  logic [7:0] width = 8'd1;
  logic [7:0] holdoff = 8'd0;
  logic       retrig = 1'b0;
  logic       clr_lost = 1'b0;
  logic       q;
  logic       busy;
  logic [7:0] nlost;

  typedef struct packed {
    logic       q;
    logic       busy;
    logic [7:0] nlost;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;

  x_pulse_stretch #(.MXCNT(8), .MXLOST(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .p       (p),
    .width   (width),
    .holdoff (holdoff),
    .retrig  (retrig),
    .clr_lost(clr_lost),
    .q       (q),
    .busy    (busy),
    .nlost   (nlost)
  );

  always #5 clock = ~clock;

  // Stimulus only: leaves the bench 1 ns after a rising edge, out of reset.
  task automatic apply_reset();
    reset_n  = 1'b0;
    p        = 1'b0;
    clr_lost = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    p       = 1'b1;
    width   = 8'd4;
    repeat (2) @(posedge clock);
    #1;
    exp_q.push_back({1'b0, 1'b0, 8'd0});
    e = exp_q.pop_front();
    n_tests++;
    if ({q, busy, nlost} !== e)
      begin n_fail++; $display("FAIL reset_held: got q=%b busy=%b nlost=%0d, want q=%b busy=%b nlost=%0d", q, busy, nlost, e.q, e.busy, e.nlost); end
    p       = 1'b0;
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({1'b0, 1'b0, 8'd0});
      @(posedge clock); #1;
      e = exp_q.pop_front();
      n_tests++;
      if ({q, busy, nlost} !== e)
        begin n_fail++; $display("FAIL reset_idle k=%0d: got q=%b busy=%b nlost=%0d, want q=%b busy=%b nlost=%0d", k, q, busy, nlost, e.q, e.busy, e.nlost); end
    end
  endtask

  task automatic test_basic();
    logic hi;
    apply_reset();
    width = 8'd4; holdoff = 8'd0; retrig = 1'b0;
    for (int k = 0; k < 10; k++) begin
      p  = (k == 2);
      hi = (k >= 2) && (k <= 5);
      exp_q.push_back({hi, hi, 8'd0});
      @(posedge clock); #1;
      e = exp_q.pop_front();
      n_tests++;
      if ({q, busy, nlost} !== e)
        begin n_fail++; $display("FAIL basic k=%0d: got q=%b busy=%b nlost=%0d, want q=%b busy=%b nlost=%0d", k, q, busy, nlost, e.q, e.busy, e.nlost); end
    end
    p = 1'b0;
  endtask

  task automatic test_zero_width_holdoff();
    logic qv, bv;
    logic [7:0] nv;
    apply_reset();
    width = 8'd0; holdoff = 8'd3; retrig = 1'b0;
    for (int k = 0; k < 12; k++) begin
      p  = (k == 0) || (k == 3) || (k == 5);
      qv = (k == 0) || (k == 5);
      bv = (k <= 3) || ((k >= 5) && (k <= 8));
      nv = (k >= 3) ? 8'd1 : 8'd0;
      exp_q.push_back({qv, bv, nv});
      @(posedge clock); #1;
      e = exp_q.pop_front();
      n_tests++;
      if ({q, busy, nlost} !== e)
        begin n_fail++; $display("FAIL zero_width k=%0d: got q=%b busy=%b nlost=%0d, want q=%b busy=%b nlost=%0d", k, q, busy, nlost, e.q, e.busy, e.nlost); end
    end
    p = 1'b0;
  endtask

  task automatic test_retrigger(input logic rt);
    logic hi;
    logic [7:0] nv;
    apply_reset();
    width = 8'd5; holdoff = 8'd0; retrig = rt;
    for (int k = 0; k < 11; k++) begin
      p  = (k == 0) || (k == 3);
      hi = rt ? (k <= 7) : (k <= 4);
      nv = (!rt && (k >= 3)) ? 8'd1 : 8'd0;
      exp_q.push_back({hi, hi, nv});
      @(posedge clock); #1;
      e = exp_q.pop_front();
      n_tests++;
      if ({q, busy, nlost} !== e)
        begin n_fail++; $display("FAIL retrig=%b k=%0d: got q=%b busy=%b nlost=%0d, want q=%b busy=%b nlost=%0d", rt, k, q, busy, nlost, e.q, e.busy, e.nlost); end
    end
    p = 1'b0;
  endtask

  // Trigger at 0, another on the last stretch/hold cycle (dropped), and one
  // on the first idle cycle (accepted): q-low gap is H+1.
  task automatic test_back_to_back(input int h);
    logic qv, bv;
    logic [7:0] nv;
    apply_reset();
    width = 8'd2; holdoff = 8'(h); retrig = 1'b0;
    for (int k = 0; k < 14; k++) begin
      p  = (k == 0) || (k == 2 + h) || (k == 3 + h);
      qv = (k <= 1) || ((k >= 3 + h) && (k <= 4 + h));
      bv = (k <= 1 + h) || ((k >= 3 + h) && (k <= 4 + 2 * h));
      nv = (k >= 2 + h) ? 8'd1 : 8'd0;
      exp_q.push_back({qv, bv, nv});
      @(posedge clock); #1;
      e = exp_q.pop_front();
      n_tests++;
      if ({q, busy, nlost} !== e)
        begin n_fail++; $display("FAIL back_to_back h=%0d k=%0d: got q=%b busy=%b nlost=%0d, want q=%b busy=%b nlost=%0d", h, k, q, busy, nlost, e.q, e.busy, e.nlost); end
    end
    p = 1'b0;
  endtask

  task automatic test_saturation();
    logic hi;
    logic [7:0] nv;
    apply_reset();
    width = 8'd255; holdoff = 8'd0; retrig = 1'b0;
    for (int k = 0; k < 303; k++) begin
      p        = (k <= 300);
      clr_lost = (k == 300) || (k == 301);
      hi       = (k <= 254) || (k >= 256);
      if (k < 255)       nv = 8'(k);
      else if (k < 300)  nv = 8'd255;
      else if (k == 300) nv = 8'd1;
      else               nv = 8'd0;
      exp_q.push_back({hi, hi, nv});
      @(posedge clock); #1;
      e = exp_q.pop_front();
      n_tests++;
      if ({q, busy, nlost} !== e)
        begin n_fail++; $display("FAIL saturation k=%0d: got q=%b busy=%b nlost=%0d, want q=%b busy=%b nlost=%0d", k, q, busy, nlost, e.q, e.busy, e.nlost); end
    end
    p = 1'b0; clr_lost = 1'b0;
  endtask

  task automatic test_async_reset();
    logic hi;
    apply_reset();
    width = 8'd10; holdoff = 8'd0; retrig = 1'b0;
    for (int k = 0; k < 5; k++) begin
      p = (k == 0) || (k == 2);
      exp_q.push_back({1'b1, 1'b1, (k >= 2) ? 8'd1 : 8'd0});
      @(posedge clock); #1;
      e = exp_q.pop_front();
      n_tests++;
      if ({q, busy, nlost} !== e)
        begin n_fail++; $display("FAIL async_pre k=%0d: got q=%b busy=%b nlost=%0d, want q=%b busy=%b nlost=%0d", k, q, busy, nlost, e.q, e.busy, e.nlost); end
    end
    p = 1'b0;
    #2.5;
    reset_n = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 8'd0});
    #1;
    e = exp_q.pop_front();
    n_tests++;
    if ({q, busy, nlost} !== e)
      begin n_fail++; $display("FAIL async_now: got q=%b busy=%b nlost=%0d, want q=%b busy=%b nlost=%0d", q, busy, nlost, e.q, e.busy, e.nlost); end
    #2;
    reset_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      p  = (k == 4);
      hi = (k >= 4) && (k <= 13);
      exp_q.push_back({hi, hi, 8'd0});
      @(posedge clock); #1;
      e = exp_q.pop_front();
      n_tests++;
      if ({q, busy, nlost} !== e)
        begin n_fail++; $display("FAIL async_post k=%0d: got q=%b busy=%b nlost=%0d, want q=%b busy=%b nlost=%0d", k, q, busy, nlost, e.q, e.busy, e.nlost); end
    end
    p = 1'b0;
  endtask

  task automatic test_latching();
    logic hi;
    apply_reset();
    width = 8'd3; holdoff = 8'd0; retrig = 1'b0;
    for (int k = 0; k < 15; k++) begin
      p = (k == 0) || (k == 4);
      if (k == 1) width = 8'd9;
      hi = (k <= 2) || ((k >= 4) && (k <= 12));
      exp_q.push_back({hi, hi, 8'd0});
      @(posedge clock); #1;
      e = exp_q.pop_front();
      n_tests++;
      if ({q, busy, nlost} !== e)
        begin n_fail++; $display("FAIL latching k=%0d: got q=%b busy=%b nlost=%0d, want q=%b busy=%b nlost=%0d", k, q, busy, nlost, e.q, e.busy, e.nlost); end
    end
    p = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_width_holdoff();
    test_retrigger(1'b1);
    test_retrigger(1'b0);
    test_back_to_back(0);
    test_back_to_back(2);
    test_saturation();
    test_async_reset();
    test_latching();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/x_pulse_stretch.md
Name: x_pulse_stretch

Overview:
- Converts single-clock trigger pulses into a level output held high for a programmable number of clocks.
- An optional holdoff (dead time) follows each output. During holdoff, new triggers are dropped and counted.
- Sits downstream of one-shot-style pulse generators. It drives wider enables into slower logic, LEDs, and cross-board strobes.

Parameters:
- MXCNT, 8, width of the stretch and holdoff counters and programming ports
- MXLOST, 8, width of the dropped-trigger counter

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- p  in  1  trigger, sampled each clock; normally a 1-clock pulse
- width  in  MXCNT  stretch length in clocks; 0 is treated as 1
- holdoff  in  MXCNT  dead time in clocks after q falls; 0 means no dead time
- retrig  in  1  1 = a trigger while stretching restarts the stretch; 0 = such a trigger is dropped
- clr_lost  in  1  synchronous clear of nlost
- q  out  1  stretched level output, registered
- busy  out  1  high when not idle (stretch or holdoff), registered
- nlost  out  MXLOST  saturating count of dropped triggers

Behaviour:
- Reset (reset_n=0, asynchronous) forces:
  - q=0, busy=0, nlost=0
  - state=idle, counters=0
- Reset asserted mid-stretch drops q immediately. No pulse resumes after reset releases.
- Let W=max(width,1) and H=holdoff.
- width and holdoff are latched at trigger acceptance (and at each retrigger). Changes mid-operation have no effect until the next acceptance.
- States: idle, stretch, hold. An illegal encoding returns to idle on the next clock.
- idle:
  - On p=1 at edge T: go to stretch, load counter with W.
  - q=1 and busy=1 from T+1.
  - Latency from p sampled to q high is one clock.
- stretch:
  - q stays high for exactly W clocks, covering T+1..T+W.
  - After the last stretch cycle, go to hold if H>0, otherwise go to idle.
- Retrigger (retrig=1): p=1 sampled during any stretch cycle, including the last, reloads the counter with W.
  - q then stays high W clocks after that edge, with no low gap.
  - q is never low between overlapping triggers.
- Retrigger disabled (retrig=0): p=1 during stretch is dropped, nlost increments, and the stretch is unaffected.
- hold:
  - q=0, busy=1 for exactly H clocks.
  - p=1 during hold is always dropped (nlost increments) regardless of retrig.
  - Then go to idle.
- Back-to-back triggers:
  - H=0: a p=1 sampled in the first idle cycle after q falls is accepted normally. The minimum q-low gap is 1 clock when retrig=0.
  - H>0: the minimum q-low gap is H+1 clocks.
- A level on p (held high) is not edge-detected: each sampled-high cycle counts as a trigger. Callers feed pulses.
- nlost:
  - Saturates at all-ones and never wraps.
  - clr_lost=1 sets it to 0.
  - clr_lost and a drop in the same cycle give nlost=1.
  - Drop events are ignored while reset is asserted.
- busy: equals (state != idle), registered alongside q.

Test Plan:
- Basic, clean reset: width=4, holdoff=0, retrig=0, single p pulse at edge 10 → q=1 on edges 11..14, 0 at 15; busy mirrors q; nlost=0.
- Zero-width and holdoff: width=0, holdoff=3, p at edge 5 → q high for edge 6 only; busy high for edges 6..9; a p at edge 8 is dropped (nlost=1) and q stays 0; a p at edge 10 is accepted and q=1 at 11.
- Retrigger: width=5, retrig=1, p at edges 20 and 23 → q high for edges 21..28 continuously, falling at 29; nlost=0. Repeat with retrig=0 → q high for edges 21..25 only, nlost=1.
- Saturation and clear: MXLOST=8, width=255, retrig=0, p held high 300 cycles → nlost=255, no wrap. Then clr_lost pulsed together with a drop → nlost=1. Then clr_lost alone → 0.
- Async reset mid-operation: width=10, p at edge 0, reset_n low at 3.5 ns after edge 4 → q, busy, nlost go to 0 without waiting for a clock. After release, q stays 0 until a new p arrives; the next p gives a fresh width-10 pulse.
- Latching: width=3 at trigger, width changed to 9 during the stretch → q is high exactly 3 clocks; the next trigger uses 9.
